// File: rtl/led_pattern_sched.sv
// led_pattern_sched
//   Button-driven controller and step scheduler for the 16-channel LED PWM bank.
//   Five raw buttons are synchronised and debounced. Each debounced press becomes
//   one command: mode, faster, slower, pause toggle or restart. When two presses
//   land in the same cycle, only the lowest-index button is acted on. A step timer
//   with period (5-speed)*PERIOD_BASE advances the current pattern (CHASE, BOUNCE
//   or BREATHE). The registered per-channel duty bus goes straight to the PWM array.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   buttons    raw buttons: [0]=mode [1]=faster [2]=slower [3]=pause [4]=restart
//   duty_flat  channel i duty at [DUTY_W*i +: DUTY_W], registered
//   step_tick  one-cycle pulse in the cycle duty_flat takes a new step value
//   mode       0=CHASE 1=BOUNCE 2=BREATHE
//   speed      speed level 0..4
//   paused     high while stepping is frozen
//
// Build option
//   LED_SCHED_GAMMA_EN : when defined, each output duty is gamma-shaped as
//                        (d*d) >> DUTY_W ahead of the output register. The
//                        pattern state itself stays linear.

module led_pattern_sched #(
    parameter int NUM_CH      = 16,
    parameter int DUTY_W      = 7,
    parameter int DEB_CYCLES  = 500000,
    parameter int PERIOD_BASE = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4:0]               buttons,
    output logic [NUM_CH*DUTY_W-1:0] duty_flat,
    output logic                     step_tick,
    output logic [1:0]               mode,
    output logic [2:0]               speed,
    output logic                     paused
);

    localparam int HEAD_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DEB_W        = $clog2(DEB_CYCLES + 1);
    localparam int CNT_W        = $clog2(5 * PERIOD_BASE);
    localparam int BREATHE_STEP = 8;
    localparam logic [DUTY_W-1:0] DMAX = '1;

    typedef enum logic [1:0] {CHASE = 2'd0, BOUNCE = 2'd1, BREATHE = 2'd2} mode_t;
    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    // ---------------------------------------------------------------- helpers
    function automatic logic [CNT_W-1:0] period_last(input logic [2:0] spd);
        case (spd)
            3'd0:    return CNT_W'(5 * PERIOD_BASE - 1);
            3'd1:    return CNT_W'(4 * PERIOD_BASE - 1);
            3'd2:    return CNT_W'(3 * PERIOD_BASE - 1);
            3'd3:    return CNT_W'(2 * PERIOD_BASE - 1);
            default: return CNT_W'(PERIOD_BASE - 1);
        endcase
    endfunction

    function automatic logic [2:0] speed_up(input logic [2:0] spd);
        return (spd >= 3'd4) ? 3'd4 : spd + 3'd1;
    endfunction

    function automatic logic [2:0] speed_down(input logic [2:0] spd);
        return (spd == 3'd0) ? 3'd0 : spd - 3'd1;
    endfunction

    // Return {clamp_hit, new_level}. A hit means the breathing direction reverses.
    function automatic logic [DUTY_W:0] level_up(input logic [DUTY_W-1:0] lvl);
        logic [DUTY_W:0] sum;
        sum = {1'b0, lvl} + (DUTY_W+1)'(BREATHE_STEP);
        if (sum >= {1'b0, DMAX}) return {1'b1, DMAX};
        return {1'b0, sum[DUTY_W-1:0]};
    endfunction

    function automatic logic [DUTY_W:0] level_down(input logic [DUTY_W-1:0] lvl);
        if (lvl <= DUTY_W'(BREATHE_STEP)) return {1'b1, {DUTY_W{1'b0}}};
        return {1'b0, lvl - DUTY_W'(BREATHE_STEP)};
    endfunction

`ifdef LED_SCHED_GAMMA_EN
    function automatic logic [DUTY_W-1:0] shape(input logic [DUTY_W-1:0] d);
        logic [2*DUTY_W-1:0] sq;
        sq = {{DUTY_W{1'b0}}, d} * {{DUTY_W{1'b0}}, d};
        return sq[2*DUTY_W-1:DUTY_W];
    endfunction
`else
    function automatic logic [DUTY_W-1:0] shape(input logic [DUTY_W-1:0] d);
        return d;
    endfunction
`endif

    // ---------------------------------------------------------------- p0/p1: synchroniser, debounce, press pulse p2
    logic [4:0]       sync_p0, sync_p1;
    logic [4:0]       deb_state, deb_prev, press_p2;
    logic [DEB_W-1:0] deb_cnt [5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0   <= '0;
            sync_p1   <= '0;
            deb_state <= '0;
            deb_prev  <= '0;
            press_p2  <= '0;
            for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
        end else begin
            sync_p0  <= buttons;
            sync_p1  <= sync_p0;
            deb_prev <= deb_state;
            press_p2 <= deb_state & ~deb_prev;
            for (int i = 0; i < 5; i++) begin
                if (sync_p1[i] == deb_state[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_cnt[i]   <= '0;
                    deb_state[i] <= sync_p1[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- command decode and step timing
    logic [4:0]       cmd;
    logic             restart, speed_chg, due, step;
    mode_t            mode_q;
    logic [CNT_W-1:0] step_cnt;

    // Keep only the lowest set bit, so the lowest-index press wins.
    assign cmd       = press_p2 & (~press_p2 + 5'd1);
    assign restart   = cmd[0] | cmd[4];
    assign speed_chg = (cmd[1] && speed != 3'd4) || (cmd[2] && speed != 3'd0);
    assign due       = !paused && (step_cnt == period_last(speed));
    // Restart and mode change take priority over a step that is due in the same cycle.
    assign step      = due && !restart;

    // ---------------------------------------------------------------- next pattern state
    logic [HEAD_W-1:0]  head, head_n;
    dir_t               dir, dir_n;
    logic [DUTY_W-1:0]  level, level_n;
    logic [DUTY_W-1:0]  lin [NUM_CH];
    logic [DUTY_W-1:0]  lin_n [NUM_CH];
    logic [DUTY_W:0]    lvl_q;
    logic [NUM_CH*DUTY_W-1:0] flat_n;

    always_comb begin
        head_n  = head;
        dir_n   = dir;
        level_n = level;
        lin_n   = lin;
        lvl_q   = '0;
        if (restart) begin
            head_n  = '0;
            dir_n   = UP;
            level_n = '0;
            for (int i = 0; i < NUM_CH; i++) lin_n[i] = '0;
        end else if (step) begin
            case (mode_q)
                CHASE: begin
                    head_n = (head == HEAD_W'(NUM_CH - 1)) ? '0 : head + 1'b1;
                    for (int i = 0; i < NUM_CH; i++)
                        lin_n[i] = (HEAD_W'(i) == head_n) ? DMAX : (lin[i] >> 1);
                end
                BOUNCE: begin
                    if (dir == UP) begin
                        if (head == HEAD_W'(NUM_CH - 1)) begin
                            dir_n  = DOWN;
                            head_n = head - 1'b1;
                        end else begin
                            head_n = head + 1'b1;
                        end
                    end else begin
                        if (head == '0) begin
                            dir_n  = UP;
                            head_n = head + 1'b1;
                        end else begin
                            head_n = head - 1'b1;
                        end
                    end
                    for (int i = 0; i < NUM_CH; i++)
                        lin_n[i] = (HEAD_W'(i) == head_n) ? DMAX : '0;
                end
                BREATHE: begin
                    lvl_q   = (dir == UP) ? level_up(level) : level_down(level);
                    level_n = lvl_q[DUTY_W-1:0];
                    if (lvl_q[DUTY_W]) dir_n = (dir == UP) ? DOWN : UP;
                    for (int i = 0; i < NUM_CH; i++) lin_n[i] = level_n;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        flat_n = '0;
        for (int i = 0; i < NUM_CH; i++)
            flat_n[DUTY_W*i +: DUTY_W] = shape(lin_n[i]);
    end

    // ---------------------------------------------------------------- registered control and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= CHASE;
            speed     <= '0;
            paused    <= 1'b0;
            step_cnt  <= '0;
            head      <= '0;
            dir       <= UP;
            level     <= '0;
            duty_flat <= '0;
            step_tick <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) lin[i] <= '0;
        end else begin
            if (cmd[0]) begin
                case (mode_q)
                    CHASE:   mode_q <= BOUNCE;
                    BOUNCE:  mode_q <= BREATHE;
                    default: mode_q <= CHASE;
                endcase
            end
            if (cmd[1]) speed <= speed_up(speed);
            if (cmd[2]) speed <= speed_down(speed);
            if (cmd[3]) paused <= ~paused;

            // While paused, the count holds so that unpausing resumes mid-period.
            if (restart || speed_chg)
                step_cnt <= '0;
            else if (due)
                step_cnt <= '0;
            else if (!paused)
                step_cnt <= step_cnt + 1'b1;

            head      <= head_n;
            dir       <= dir_n;
            level     <= level_n;
            lin       <= lin_n;
            duty_flat <= flat_n;
            step_tick <= step;
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Directed, table-driven bench for led_pattern_sched with a short debounce and a short step period.

module tb_led_pattern_sched;

    localparam int NUM_CH = 16;
    localparam int DUTY_W = 7;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [4:0]               buttons = '0;
    logic [NUM_CH*DUTY_W-1:0] duty_flat;
    logic                     step_tick;
    logic [1:0]               mode;
    logic [2:0]               speed;
    logic                     paused;

    led_pattern_sched #(
        .NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .DEB_CYCLES(4), .PERIOD_BASE(10)
    ) dut (
        .clk(clk), .rst(rst), .buttons(buttons), .duty_flat(duty_flat),
        .step_tick(step_tick), .mode(mode), .speed(speed), .paused(paused)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0] btn;
        logic [2:0] spd;
        logic       psd;
    } vec_t;
    vec_t tbl [12];

    function automatic int g(input int x);
`ifdef LED_SCHED_GAMMA_EN
        return (x * x) >> 7;
`else
        return x;
`endif
    endfunction

    function automatic int ch(input int i);
        logic [6:0] v;
        v = duty_flat[DUTY_W*i +: DUTY_W];
        return int'(v);
    endfunction

    function automatic int nonzero_count();
        int c;
        c = 0;
        for (int i = 0; i < NUM_CH; i++) if (ch(i) != 0) c++;
        return c;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Returns the number of falling edges until step_tick is seen. A missing tick counts as a failure.
    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step_tick && n < limit);
        if (!step_tick) begin
            n_cmp++;
            n_err++;
            $display("FAIL tick_timeout: got no tick in %0d cycles, expected one", limit);
        end
    endtask

    task automatic press(input logic [4:0] mask);
        buttons = mask;
        repeat (10) @(negedge clk);
        buttons = '0;
        repeat (10) @(negedge clk);
    endtask

    // Hold the mode button until the mode changes, then check the restart cycle.
    task automatic mode_press(input int want, input string name);
        int n;
        n = 0;
        buttons = 5'b00001;
        do begin
            @(negedge clk);
            n++;
        end while (mode != 2'(want) && n < 20);
        check({name, "_mode"}, int'(mode), want);
        check({name, "_duty_zero"}, int'(duty_flat == '0), 1);
        check({name, "_no_tick"}, int'(step_tick), 0);
        buttons = '0;
    endtask

    initial begin
        int n, e;

        tbl[0]  = '{5'b00010, 3'd1, 1'b0};
        tbl[1]  = '{5'b00010, 3'd2, 1'b0};
        tbl[2]  = '{5'b00010, 3'd3, 1'b0};
        tbl[3]  = '{5'b00010, 3'd4, 1'b0};
        tbl[4]  = '{5'b00010, 3'd4, 1'b0};
        tbl[5]  = '{5'b00100, 3'd3, 1'b0};
        tbl[6]  = '{5'b00100, 3'd2, 1'b0};
        tbl[7]  = '{5'b00100, 3'd1, 1'b0};
        tbl[8]  = '{5'b00100, 3'd0, 1'b0};
        tbl[9]  = '{5'b00100, 3'd0, 1'b0};
        tbl[10] = '{5'b01000, 3'd0, 1'b1};
        tbl[11] = '{5'b01000, 3'd0, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_duty", int'(duty_flat == '0), 1);
        check("rst_tick", int'(step_tick), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_speed", int'(speed), 0);
        check("rst_paused", int'(paused), 0);
        rst = 1'b0;

        // CHASE at speed 0.
        wait_tick(60, n);
        check("chase_t1_interval", n, 50);
        check("chase_t1_ch1", ch(1), g(127));
        check("chase_t1_ch0", ch(0), 0);
        wait_tick(60, n);
        check("chase_t2_interval", n, 50);
        check("chase_t2_ch2", ch(2), g(127));
        check("chase_t2_ch1", ch(1), g(63));
        for (int k = 3; k <= 16; k++) wait_tick(60, n);
        check("chase_t16_interval", n, 50);
        check("chase_t16_ch0", ch(0), g(127));
        check("chase_t16_ch15", ch(15), g(63));
        check("chase_t16_ch14", ch(14), g(31));

        // Speed up to saturation.
        for (int i = 0; i <= 4; i++) begin
            press(tbl[i].btn);
            check($sformatf("tbl%0d_speed", i), int'(speed), int'(tbl[i].spd));
            check($sformatf("tbl%0d_paused", i), int'(paused), int'(tbl[i].psd));
        end
        wait_tick(60, n);
        wait_tick(60, n);
        check("speed4_interval", n, 10);

        // A two-cycle glitch on the slower button must be ignored.
        buttons = 5'b00100;
        repeat (2) @(negedge clk);
        buttons = '0;
        repeat (20) @(negedge clk);
        check("glitch_speed", int'(speed), 4);

        // Speed down to saturation, then a pause toggle pair.
        for (int i = 5; i <= 11; i++) begin
            press(tbl[i].btn);
            check($sformatf("tbl%0d_speed", i), int'(speed), int'(tbl[i].spd));
            check($sformatf("tbl%0d_paused", i), int'(paused), int'(tbl[i].psd));
        end
        wait_tick(60, n);
        wait_tick(60, n);
        check("speed0_interval", n, 50);

        // BOUNCE.
        mode_press(1, "to_bounce");
        for (int k = 1; k <= 31; k++) begin
            wait_tick(60, n);
            if (k == 1) check("bounce_first_interval", n, 50);
            e = (k <= 15) ? k : ((k <= 30) ? 30 - k : 1);
            check($sformatf("bounce_t%0d_head", k), ch(e), g(127));
            check($sformatf("bounce_t%0d_single", k), nonzero_count(), 1);
        end

        // BREATHE.
        mode_press(2, "to_breathe");
        for (int k = 1; k <= 33; k++) begin
            wait_tick(60, n);
            if (k <= 15)      e = 8 * k;
            else if (k == 16) e = 127;
            else if (k <= 31) e = 127 - 8 * (k - 16);
            else if (k == 32) e = 0;
            else              e = 8;
            check($sformatf("breathe_t%0d_ch0", k), ch(0), g(e));
            check($sformatf("breathe_t%0d_ch15", k), ch(15), g(e));
        end

        // Mode wraps back to CHASE.
        mode_press(0, "to_chase");

        // Pause in mid-period, then resume from the held count.
        wait_tick(60, n);
        repeat (12) @(negedge clk);
        buttons = 5'b01000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!paused && n < 20);
        check("pause_on", int'(paused), 1);
        buttons = '0;
        e = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (step_tick) e++;
        end
        check("pause_no_ticks", e, 0);
        buttons = 5'b01000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (paused && n < 20);
        check("pause_off", int'(paused), 0);
        buttons = '0;
        wait_tick(60, n);
        check("resume_interval", n, 30);

        // Faster and restart pressed together: only the speed command acts.
        buttons = 5'b10010;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (speed != 3'd1 && n < 20);
        buttons = '0;
        check("simul_speed", int'(speed), 1);
        check("simul_mode", int'(mode), 0);
        check("simul_ch2_kept", ch(2), g(127));
        check("simul_ch1_kept", ch(1), g(63));

        // Asynchronous reset between clock edges.
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_duty", int'(duty_flat == '0), 1);
        check("async_rst_speed", int'(speed), 0);
        check("async_rst_mode", int'(mode), 0);
        check("async_rst_tick", int'(step_tick), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_tick(60, n);
        check("post_rst_interval", n, 50);
        check("post_rst_ch1", ch(1), g(127));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
